// File: rtl/spi_txn_sequencer.sv
// Register read/write sequencer that frames 40-bit datagrams for the stepper-driver SPI master.
// Optional per-phase frame timeout is built when SPI_TXN_TIMEOUT_EN is defined.
module spi_txn_sequencer #(
  parameter int unsigned SIZE           = 40,
  parameter int unsigned CS_SIZE        = 1,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [6:0]         req_addr,
  input  logic [31:0]        req_data,
  input  logic [CS_SIZE-1:0] req_cs,
  output logic               resp_valid,
  output logic [7:0]         resp_status,
  output logic [31:0]        resp_data,
  output logic               resp_error,
  output logic [SIZE-1:0]    spi_data_out,
  output logic               spi_send_enable,
  output logic [CS_SIZE-1:0] spi_cs_select,
  input  logic [SIZE-1:0]    spi_data_in,
  input  logic               spi_send_n
);

  typedef enum logic [2:0] {IDLE, ARM, BUSY, GAP, DONE} state_t;

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  state_t           state, state_nxt;
  logic [1:0]       frame_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             send_n_q, send_n_prev;
  logic             fall, rise;
  logic             accept, capture, abort, timeout;

  // Edges come only from the registered copy, so a stale low level never starts a frame.
  assign fall = send_n_prev & ~send_n_q;
  assign rise = ~send_n_prev & send_n_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    capture         = 1'b0;
    abort           = 1'b0;
    req_ready       = 1'b0;
    spi_send_enable = 1'b0;
    resp_valid      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        spi_send_enable = 1'b1;
        if (fall) begin
          state_nxt = BUSY;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = GAP;
        end
      end
      BUSY: begin
        spi_send_enable = 1'b1;
        if (rise) begin
          capture   = 1'b1;
          state_nxt = GAP;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_nxt = (frame_cnt != 2'd0) ? ARM : DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      send_n_q      <= 1'b1;
      send_n_prev   <= 1'b1;
      frame_cnt     <= '0;
      gap_cnt       <= '0;
      spi_data_out  <= '0;
      spi_cs_select <= '0;
      resp_status   <= '0;
      resp_data     <= '0;
    end else begin
      send_n_q    <= spi_send_n;
      send_n_prev <= send_n_q;
      gap_cnt     <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (accept) begin
        spi_data_out  <= SIZE'({req_write, req_addr, req_write ? req_data : 32'h0});
        spi_cs_select <= req_cs;
        frame_cnt     <= req_write ? 2'd1 : 2'd2;
      end else if (capture) begin
        frame_cnt <= frame_cnt - 2'd1;
      end else if (abort) begin
        frame_cnt <= '0;
      end
      if (capture) begin
        resp_status <= spi_data_in[SIZE-1 -: 8];
        resp_data   <= spi_data_in[31:0];
      end
    end
  end

`ifdef SPI_TXN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] phase_cnt;
  logic            phase_entry;
  logic            in_phase;

  assign in_phase    = (state == ARM) || (state == BUSY);
  assign phase_entry = (state_nxt != state) && ((state_nxt == ARM) || (state_nxt == BUSY));
  assign timeout     = in_phase && (phase_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_cnt  <= '0;
      resp_error <= 1'b0;
    end else begin
      if (phase_entry) begin
        phase_cnt <= '0;
      end else if (in_phase) begin
        phase_cnt <= phase_cnt + TO_W'(1);
      end
      if (accept) begin
        resp_error <= 1'b0;
      end else if (abort) begin
        resp_error <= 1'b1;
      end
    end
  end
`else
  assign timeout    = 1'b0;
  assign resp_error = 1'b0;
`endif

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Upstream command stage for the 40-bit SPI master that drives the stepper drivers.
- Accepts register read/write requests over a valid/ready handshake and packs each one into a 40-bit datagram.
- Pulses the SPI master's send enable for one frame per datagram, detects frame end on the master's active-low send flag, and returns driver status plus read data.
- Driver reads are pipelined by one frame, so a read issues two frames and returns data captured from the second.

Parameters:
- SIZE, 40, datagram width; fixed layout: bit 39 write flag, 38:32 address, 31:0 data.
- CS_SIZE, 1, width of the chip-select index passed to the SPI master.
- GAP_CYCLES, 16, clk_in cycles send enable is held low between frames; must be at least 2 divided SPI clock periods plus 2.
- TIMEOUT_CYCLES, 4096, clk_in cycles allowed per frame phase (used only with the optional feature).

Ports:
- clk_in  input  1  system clock; the same clock that feeds the SPI master.
- rst_in  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  7  driver register address.
- req_data  input  32  write data; ignored for reads.
- req_cs  input  CS_SIZE  target driver index.
- resp_valid  output  1  one-cycle pulse; response fields valid.
- resp_status  output  8  bits 39:32 of the last received frame.
- resp_data  output  32  bits 31:0 of the last received frame.
- resp_error  output  1  frame timed out (optional feature only; otherwise tied 0).
- spi_data_out  output  SIZE  datagram to the master's data input.
- spi_send_enable  output  1  to the master's send enable input.
- spi_cs_select  output  CS_SIZE  to the master's chip-select index input.
- spi_data_in  input  SIZE  from the master's received-data output.
- spi_send_n  input  1  from the master's active-low frame-active output.

Behaviour:
- Reset values (async on rst_in high): state IDLE, req_ready 1, resp_valid 0, resp_status 0, resp_data 0, resp_error 0, spi_send_enable 0, spi_data_out 0, spi_cs_select 0, internal counters 0.
- spi_send_n is registered once in clk_in; all edge detection uses the registered copy and its previous value.
- IDLE:
  - req_ready is 1.
  - On req_valid && req_ready, latch the request, load spi_data_out = {req_write, req_addr, req_write ? req_data : 32'h0} and spi_cs_select = req_cs.
  - Set the frame counter: 1 for a write, 2 for a read. Go to ARM.
  - req_ready drops the cycle after acceptance.
- ARM:
  - spi_send_enable is 1.
  - On a registered falling edge of spi_send_n (frame started), go to BUSY.
- BUSY:
  - spi_send_enable stays 1.
  - On a registered rising edge of spi_send_n (frame ended), capture spi_data_in into resp_status/resp_data, decrement the frame counter, go to GAP.
- GAP:
  - spi_send_enable is 0 for exactly GAP_CYCLES cycles, which resets the master's frame counter.
  - Then go to ARM if the frame counter is non-zero (second read frame, same datagram), otherwise go to DONE.
- DONE:
  - resp_valid is high for exactly one cycle.
  - Next state is IDLE with req_ready 1.
  - Total handshake-to-resp_valid latency is deterministic for a given SPI clock divider.
- Request fields change while busy: ignored, because the request is latched.
- spi_data_out and spi_cs_select are stable from ARM entry until IDLE.
- req_valid held high continuously: a new request is accepted on the first IDLE cycle after DONE. Back-to-back requests are therefore separated by at least GAP_CYCLES + 2 cycles of send enable low.
- spi_send_n already low on entry to ARM (stale frame): no falling edge is seen, so the block waits. It never advances on level, only on edges.
- Reset mid-frame: spi_send_enable drops immediately. No resp_valid is issued for the aborted request.
- resp_status/resp_data hold their last values until the next capture.

Optional Feature:
- Macro: SPI_TXN_TIMEOUT_EN.
- With the macro defined:
  - A phase counter resets on every entry to ARM or BUSY.
  - If it reaches TIMEOUT_CYCLES before the awaited edge, drop spi_send_enable and set resp_error = 1.
  - Clear the frame counter, wait through GAP, then pulse resp_valid in DONE with resp_status/resp_data unchanged.
  - resp_error clears on the next request acceptance.
- Without the macro: no counter is built, resp_error is constant 0, and ARM/BUSY wait indefinitely.

Test Plan:
- Write, addr 0x6C, data 0x000101D5, cs 0 -> one frame; spi_data_out = 0xEC000101D5; resp_valid pulses once; resp_status = bits 39:32 returned by the driver model.
- Read, addr 0x6F, model returns 0x0A_12345678 on frame 2 -> exactly two enable pulses, both datagrams 0x6F00000000; resp_data = 0x12345678, resp_status = 0x0A.
- req_valid held high with 3 queued writes -> 3 frames, each enable-low gap ≥ GAP_CYCLES (16); 3 resp_valid pulses; req_ready low throughout each transaction.
- rst_in asserted during BUSY of a read -> spi_send_enable 0 asynchronously, req_ready 1 after release, no resp_valid; next write completes normally.
- SPI_TXN_TIMEOUT_EN defined, model never drops spi_send_n, TIMEOUT_CYCLES = 64 -> spi_send_enable falls after 64 cycles in ARM; resp_valid with resp_error = 1; the next request clears resp_error.
- spi_send_n held low before a request -> block stays in ARM with no response until a clean high-to-low edge occurs.
